fp_accum_seq: RTL and testbench
===============================

Name: fp_accum_seq

Overview:
Initiator for the floating-point add/sub unit. Accepts a stream of IEEE-754 single-precision terms and issues one add request per term to the addsub unit over the add_start/add_busy/add_done/add_serv handshake. Accumulates the running sum and presents the final sum of N_TERMS terms to the downstream consumer. Sits between an operand source (e.g. a series-expansion generator) and addsub.

Parameters:
N_TERMS, 8, number of terms summed per result (>=1)
TIMEOUT, 64, max cycles in WAIT_DONE before an error is flagged (>=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  term available on in_data
in_ready  out  1  block accepts a term this cycle
in_data  in  32  IEEE-754 single term
op1  out  32  addsub operand 1 (running accumulator)
op2  out  32  addsub operand 2 (latched term)
add_start  out  1  one-cycle add request
add_busy  in  1  addsub is computing
add_done  in  1  one-cycle pulse; add_result valid
add_result  in  32  addsub sum
add_overflow  in  1  overflow, qualified by add_done
add_serv  out  1  one-cycle acknowledge that the result has been consumed
sum_valid  out  1  final sum available
sum_ready  in  1  consumer accepts the sum
sum_data  out  32  final sum
sum_overflow  out  1  sticky OR of add_overflow over this sum
sum_err  out  1  an add timed out

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. While rst is sampled high, the block enters IDLE:
  - acc, term, count, overflow and err all clear.
  - All outputs are 0, including op1 and op2.
- A reset mid-operation abandons the sum. add_start and add_serv are 0 from the next cycle. A late add_done is ignored.
- States: IDLE, WAIT_TERM, ISSUE, WAIT_DONE, ACK, OUTPUT.
- in_ready = 1 only in IDLE and WAIT_TERM. A term transfers when in_valid && in_ready.
- IDLE + transfer: acc <= in_data, count <= 1. No add is issued.
  - If N_TERMS == 1, go to OUTPUT.
  - Otherwise go to WAIT_TERM.
- WAIT_TERM + transfer: term <= in_data, go to ISSUE.
- ISSUE:
  - op1 = acc and op2 = term, driven from registers.
  - If add_busy == 0, assert add_start for exactly this one cycle and go to WAIT_DONE.
  - If add_busy == 1, hold add_start = 0 and stay in ISSUE.
- WAIT_DONE:
  - op1 and op2 are held stable.
  - The timeout counter increments each cycle.
  - On add_done: acc <= add_result, overflow <= overflow | add_overflow, go to ACK.
  - If the counter reaches TIMEOUT with no add_done: err <= 1, go to OUTPUT with acc unchanged.
- ACK:
  - add_serv = 1 for this one cycle.
  - count <= count + 1.
  - If count + 1 == N_TERMS, go to OUTPUT; else go to WAIT_TERM.
- add_done sampled in any state other than WAIT_DONE is ignored.
- OUTPUT:
  - sum_valid = 1, sum_data = acc, sum_overflow = overflow, sum_err = err.
  - All four are held stable until sum_ready. sum_valid may wait indefinitely.
  - On sum_valid && sum_ready: go to IDLE and clear acc, count, overflow, err.
  - sum_valid drops the next cycle.
- Latency per add: 1 cycle (ISSUE) + addsub latency + 1 cycle (ACK).
- count width is $clog2(N_TERMS+1). The timeout counter width is $clog2(TIMEOUT+1). The timeout counter clears on entry to WAIT_DONE.
- No floating-point arithmetic happens in this block. Values pass through bit-exact.

Test Plan:
- N_TERMS=2; feed 0x40200000 then 0x40600000; addsub model returns 0x40C00000 after 5 cycles -> exactly one add_start pulse with op1=0x40200000, op2=0x40600000; add_serv one cycle after done; sum_data=0x40C00000, sum_overflow=0, sum_err=0.
- N_TERMS=3; terms 0xC4000000, 0x44000000, 0x40200000; model returns 0x00000000 then 0x40200000 -> two add requests; second request has op1=0x00000000; sum_data=0x40200000.
- Hold add_busy=1 for 10 cycles while in ISSUE -> add_start stays 0; it pulses in the first cycle add_busy=0; op1/op2 stable throughout.
- Model asserts add_overflow=1 on the first of two adds only -> sum_overflow=1 at OUTPUT; cleared for the next sum.
- TIMEOUT=16; model never returns add_done -> sum_valid with sum_err=1 exactly 16 cycles after entering WAIT_DONE; sum_data=first term; no add_serv pulse.
- sum_ready held low 20 cycles -> sum_valid and sum_data are stable and in_ready=0. Separately, assert rst during WAIT_DONE, then pulse add_done -> all outputs 0, state IDLE, done ignored, no add_serv.

Source files
------------

// File: rtl/fp_accum_seq_if.sv
// fp_accum_seq_if -- bundle of every non-clock signal of fp_accum_seq.
//
// Groups three channels:
//   term stream   : in_valid / in_ready / in_data        (source -> block)
//   addsub bus    : op1, op2, add_start, add_busy, add_done,
//                   add_result, add_overflow, add_serv
//   sum stream    : sum_valid / sum_ready / sum_data, sum_overflow, sum_err
//
// Handshake semantics:
//   A valid/ready stream transfers one item on every rising clk edge where
//   valid && ready. Once raised, valid and its data stay stable until that
//   transfer happens. ready may depend on state but never on valid.
//   On the addsub bus, add_start and add_serv are single-cycle pulses, and
//   add_done is a single-cycle pulse that qualifies add_result/add_overflow.
//
// Modports:
//   master : the accumulator side (fp_accum_seq)
//   slave  : the environment side (term source, addsub unit, sum consumer)
`timescale 1ns/1ps
interface fp_accum_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;

  logic [31:0] op1;
  logic [31:0] op2;
  logic        add_start;
  logic        add_busy;
  logic        add_done;
  logic [31:0] add_result;
  logic        add_overflow;
  logic        add_serv;

  logic        sum_valid;
  logic        sum_ready;
  logic [31:0] sum_data;
  logic        sum_overflow;
  logic        sum_err;

  modport master (
    input  in_valid, in_data,
    input  add_busy, add_done, add_result, add_overflow,
    input  sum_ready,
    output in_ready,
    output op1, op2, add_start, add_serv,
    output sum_valid, sum_data, sum_overflow, sum_err
  );

  modport slave (
    output in_valid, in_data,
    output add_busy, add_done, add_result, add_overflow,
    output sum_ready,
    input  in_ready,
    input  op1, op2, add_start, add_serv,
    input  sum_valid, sum_data, sum_overflow, sum_err
  );
endinterface

// File: rtl/fp_accum_seq.sv
// fp_accum_seq -- sequences N_TERMS single-precision terms through an
// external add/sub unit and presents their running sum.
//
// The first term of each sum is loaded straight into the accumulator; every
// following term is latched and issued as one add request (op1 = acc,
// op2 = term). The returned result becomes the new accumulator. After
// N_TERMS terms, or after an add times out, the sum is offered on the sum
// stream. No arithmetic is done here: values pass through bit-exact.
//
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous, active-high reset; all outputs read 0 while high
//   bus       : fp_accum_seq_if.master (term stream, addsub bus, sum stream)
//   dbg_state : current FSM state encoding
//               0 IDLE, 1 WAIT_TERM, 2 ISSUE, 3 WAIT_DONE, 4 ACK, 5 OUTPUT
`timescale 1ns/1ps
module fp_accum_seq #(
  parameter int N_TERMS = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  fp_accum_seq_if.master      bus,
  output logic [2:0]          dbg_state
);

  localparam int CW = $clog2(N_TERMS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TERM = 3'd1,
    ISSUE     = 3'd2,
    WAIT_DONE = 3'd3,
    ACK       = 3'd4,
    OUTPUT    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   acc_q, acc_d;
  logic [31:0]   term_q, term_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;

  logic          accept_state;
  logic          xfer;

  assign accept_state = (state_q == IDLE) || (state_q == WAIT_TERM);
  // rst overrides any transfer, so the ungated ready is enough here.
  assign xfer         = bus.in_valid && accept_state;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    term_d  = term_q;
    count_d = count_q;
    tmo_d   = tmo_q;
    ovf_d   = ovf_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          // First term seeds the accumulator without an add.
          acc_d   = bus.in_data;
          count_d = CW'(1);
          state_d = (N_TERMS == 1) ? OUTPUT : WAIT_TERM;
        end
      end
      WAIT_TERM: begin
        if (xfer) begin
          term_d  = bus.in_data;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.add_busy) begin
          tmo_d   = '0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // add_done wins over a timeout landing in the same cycle.
        if (bus.add_done) begin
          acc_d   = bus.add_result;
          ovf_d   = ovf_q | bus.add_overflow;
          state_d = ACK;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // TIMEOUT cycles spent here without a result: give up, keep acc.
          err_d   = 1'b1;
          state_d = OUTPUT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ACK: begin
        count_d = count_q + CW'(1);
        state_d = (count_q == CW'(N_TERMS - 1)) ? OUTPUT : WAIT_TERM;
      end
      OUTPUT: begin
        if (bus.sum_ready) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      term_q  <= '0;
      count_q <= '0;
      tmo_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      term_q  <= term_d;
      count_q <= count_d;
      tmo_q   <= tmo_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // Outputs are forced low while rst is high so that the cycle in which
  // reset is sampled already shows an all-zero interface.
  always_comb begin
    bus.in_ready     = 1'b0;
    bus.op1          = '0;
    bus.op2          = '0;
    bus.add_start    = 1'b0;
    bus.add_serv     = 1'b0;
    bus.sum_valid    = 1'b0;
    bus.sum_data     = '0;
    bus.sum_overflow = 1'b0;
    bus.sum_err      = 1'b0;
    if (!rst) begin
      bus.in_ready  = accept_state;
      bus.op1       = acc_q;
      bus.op2       = term_q;
      bus.add_start = (state_q == ISSUE) && !bus.add_busy;
      bus.add_serv  = (state_q == ACK);
      if (state_q == OUTPUT) begin
        bus.sum_valid    = 1'b1;
        bus.sum_data     = acc_q;
        bus.sum_overflow = ovf_q;
        bus.sum_err      = err_q;
      end
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_fp_accum_seq.sv
`timescale 1ns/1ps
module tb_fp_accum_seq;

  // Channel 0: N_TERMS=2, TIMEOUT=16.  Channel 1: N_TERMS=3, TIMEOUT=64.

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- per-channel drive / observe ----------------
  logic        in_valid[2];
  logic [31:0] in_data[2];
  logic        add_busy[2];
  logic        add_done[2];
  logic [31:0] add_result[2];
  logic        add_overflow[2];
  logic        sum_ready[2];

  logic        in_ready_o[2];
  logic [31:0] op1_o[2];
  logic [31:0] op2_o[2];
  logic        add_start_o[2];
  logic        add_serv_o[2];
  logic        sum_valid_o[2];
  logic [31:0] sum_data_o[2];
  logic        sum_ovf_o[2];
  logic        sum_err_o[2];
  logic [2:0]  dbg_a, dbg_b;

  fp_accum_seq_if ia ();
  fp_accum_seq_if ib ();

  fp_accum_seq #(.N_TERMS(2), .TIMEOUT(16)) dut_a (
    .clk(clk), .rst(rst), .bus(ia), .dbg_state(dbg_a)
  );
  fp_accum_seq #(.N_TERMS(3), .TIMEOUT(64)) dut_b (
    .clk(clk), .rst(rst), .bus(ib), .dbg_state(dbg_b)
  );

  assign ia.in_valid = in_valid[0];  assign ib.in_valid = in_valid[1];
  assign ia.in_data  = in_data[0];   assign ib.in_data  = in_data[1];
  assign ia.add_busy = add_busy[0];  assign ib.add_busy = add_busy[1];
  assign ia.add_done = add_done[0];  assign ib.add_done = add_done[1];
  assign ia.add_result   = add_result[0];   assign ib.add_result   = add_result[1];
  assign ia.add_overflow = add_overflow[0]; assign ib.add_overflow = add_overflow[1];
  assign ia.sum_ready = sum_ready[0]; assign ib.sum_ready = sum_ready[1];

  assign in_ready_o[0]  = ia.in_ready;     assign in_ready_o[1]  = ib.in_ready;
  assign op1_o[0]       = ia.op1;          assign op1_o[1]       = ib.op1;
  assign op2_o[0]       = ia.op2;          assign op2_o[1]       = ib.op2;
  assign add_start_o[0] = ia.add_start;    assign add_start_o[1] = ib.add_start;
  assign add_serv_o[0]  = ia.add_serv;     assign add_serv_o[1]  = ib.add_serv;
  assign sum_valid_o[0] = ia.sum_valid;    assign sum_valid_o[1] = ib.sum_valid;
  assign sum_data_o[0]  = ia.sum_data;     assign sum_data_o[1]  = ib.sum_data;
  assign sum_ovf_o[0]   = ia.sum_overflow; assign sum_ovf_o[1]   = ib.sum_overflow;
  assign sum_err_o[0]   = ia.sum_err;      assign sum_err_o[1]   = ib.sum_err;

  // Pulse counters sampled on the active edge.
  int starts[2] = '{0, 0};
  int servs[2]  = '{0, 0};
  always @(posedge clk) begin
    if (add_start_o[0]) starts[0]++;
    if (add_start_o[1]) starts[1]++;
    if (add_serv_o[0])  servs[0]++;
    if (add_serv_o[1])  servs[1]++;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bound_fail(input string tag, input int waited);
    n_cmp++;
    n_err++;
    $display("FAIL %s: waited %0d cycles without the expected event", tag, waited);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int ch, input logic [31:0] d);
    int n;
    n = 0;
    in_valid[ch] = 1'b1;
    in_data[ch]  = d;
    while (!in_ready_o[ch] && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) bound_fail("feed_wait", n);
    tick();
    in_valid[ch] = 1'b0;
  endtask

  // Returns op1/op2 seen in the add_start cycle; leaves us in WAIT_DONE cycle 0.
  task automatic wait_start(input int ch, output logic [31:0] o1, output logic [31:0] o2);
    int n;
    n = 0;
    while (!add_start_o[ch] && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) bound_fail("start_wait", n);
    o1 = op1_o[ch];
    o2 = op2_o[ch];
    tick();
  endtask

  task automatic do_add(input int ch, input int lat, input logic [31:0] res, input logic ovf);
    repeat (lat - 1) tick();
    add_done[ch]     = 1'b1;
    add_result[ch]   = res;
    add_overflow[ch] = ovf;
    tick();
    add_done[ch]     = 1'b0;
    add_overflow[ch] = 1'b0;
    add_result[ch]   = 32'h0;
    check("serv_pulse", add_serv_o[ch], 1'b1);
    tick();
    check("serv_drop", add_serv_o[ch], 1'b0);
  endtask

  task automatic take_sum(input int ch, input logic [31:0] d, input logic o, input logic e);
    int n;
    n = 0;
    while (!sum_valid_o[ch] && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) bound_fail("sum_wait", n);
    exp_q.push_back(d);
    check("sum_data", sum_data_o[ch], exp_q.pop_front());
    check("sum_ovf", sum_ovf_o[ch], o);
    check("sum_err", sum_err_o[ch], e);
    sum_ready[ch] = 1'b1;
    tick();
    sum_ready[ch] = 1'b0;
    check("sum_valid_drop", sum_valid_o[ch], 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    logic [31:0] o1, o2;
    int s0, v0, cyc;
    logic stable;

    for (int c = 0; c < 2; c++) begin
      in_valid[c] = 1'b0; in_data[c] = '0; add_busy[c] = 1'b0;
      add_done[c] = 1'b0; add_result[c] = '0; add_overflow[c] = 1'b0;
      sum_ready[c] = 1'b0;
    end

    // Reset state, observed while rst is still high.
    rst = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", in_ready_o[0], 1'b0);
    check("rst_sum_valid", sum_valid_o[0], 1'b0);
    check("rst_op1", op1_o[0], 32'h0);
    check("rst_state", dbg_a, 3'd0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready_o[0], 1'b1);

    // Two-term sum, 5-cycle addsub.
    s0 = starts[0]; v0 = servs[0];
    feed(0, 32'h40200000);
    feed(0, 32'h40600000);
    wait_start(0, o1, o2);
    check("t1_op1", o1, 32'h40200000);
    check("t1_op2", o2, 32'h40600000);
    do_add(0, 5, 32'h40C00000, 1'b0);
    take_sum(0, 32'h40C00000, 1'b0, 1'b0);
    check("t1_starts", starts[0] - s0, 1);
    check("t1_servs", servs[0] - v0, 1);

    // Three-term sum on the second instance; second add uses returned acc.
    s0 = starts[1];
    feed(1, 32'hC4000000);
    feed(1, 32'h44000000);
    wait_start(1, o1, o2);
    check("t2_op1a", o1, 32'hC4000000);
    check("t2_op2a", o2, 32'h44000000);
    do_add(1, 3, 32'h00000000, 1'b0);
    feed(1, 32'h40200000);
    wait_start(1, o1, o2);
    check("t2_op1b", o1, 32'h00000000);
    check("t2_op2b", o2, 32'h40200000);
    do_add(1, 2, 32'h40200000, 1'b0);
    take_sum(1, 32'h40200000, 1'b0, 1'b0);
    check("t2_starts", starts[1] - s0, 2);

    // Timeout: addsub never answers.
    v0 = servs[0];
    feed(0, 32'h3F800000);
    feed(0, 32'h40000000);
    wait_start(0, o1, o2);
    cyc = 0;
    while (!sum_valid_o[0] && cyc < 40) begin
      tick();
      cyc++;
    end
    check("tmo_cycles", cyc, 16);
    check("tmo_err", sum_err_o[0], 1'b1);
    check("tmo_data", sum_data_o[0], 32'h3F800000);
    check("tmo_no_serv", servs[0] - v0, 0);

    // Consumer stalls for 20 cycles: output must hold, no term accepted.
    stable = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0]  = 32'h12345678;
    for (int i = 0; i < 20; i++) begin
      if (sum_valid_o[0] !== 1'b1 || sum_data_o[0] !== 32'h3F800000 ||
          sum_err_o[0] !== 1'b1 || in_ready_o[0] !== 1'b0)
        stable = 1'b0;
      tick();
    end
    in_valid[0] = 1'b0;
    check("hold_stable", stable, 1'b1);
    take_sum(0, 32'h3F800000, 1'b0, 1'b1);

    // add_busy holds the request off for 10 cycles.
    add_busy[0] = 1'b1;
    feed(0, 32'h3F800000);
    feed(0, 32'h40000000);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (add_start_o[0] !== 1'b0 || op1_o[0] !== 32'h3F800000 || op2_o[0] !== 32'h40000000)
        stable = 1'b0;
      tick();
    end
    check("busy_hold", stable, 1'b1);
    add_busy[0] = 1'b0;
    #1;
    check("busy_release_start", add_start_o[0], 1'b1);
    wait_start(0, o1, o2);
    check("busy_op1", o1, 32'h3F800000);
    check("busy_op2", o2, 32'h40000000);
    do_add(0, 2, 32'h40400000, 1'b0);
    take_sum(0, 32'h40400000, 1'b0, 1'b0);

    // Overflow on the first of two adds is sticky, then cleared.
    feed(1, 32'h7F000000);
    feed(1, 32'h7F000000);
    wait_start(1, o1, o2);
    do_add(1, 2, 32'h7F800000, 1'b1);
    feed(1, 32'hFF000000);
    wait_start(1, o1, o2);
    check("ovf_op1b", o1, 32'h7F800000);
    do_add(1, 2, 32'h7F800000, 1'b0);
    take_sum(1, 32'h7F800000, 1'b1, 1'b0);
    feed(1, 32'h3F800000);
    feed(1, 32'h3F800000);
    wait_start(1, o1, o2);
    do_add(1, 2, 32'h40000000, 1'b0);
    feed(1, 32'h3F800000);
    wait_start(1, o1, o2);
    check("clr_op1b", o1, 32'h40000000);
    do_add(1, 2, 32'h40400000, 1'b0);
    take_sum(1, 32'h40400000, 1'b0, 1'b0);

    // Reset during WAIT_DONE, then a late add_done.
    v0 = servs[0];
    feed(0, 32'h41000000);
    feed(0, 32'h41100000);
    wait_start(0, o1, o2);
    tick();
    check("pre_rst_state", dbg_a, 3'd3);
    rst = 1'b1;
    tick();
    check("mid_rst_state", dbg_a, 3'd0);
    check("mid_rst_op1", op1_o[0], 32'h0);
    check("mid_rst_op2", op2_o[0], 32'h0);
    check("mid_rst_start", add_start_o[0], 1'b0);
    check("mid_rst_sum_valid", sum_valid_o[0], 1'b0);
    rst = 1'b0;
    add_done[0]   = 1'b1;
    add_result[0] = 32'hDEADBEEF;
    tick();
    add_done[0]   = 1'b0;
    add_result[0] = 32'h0;
    check("late_done_state", dbg_a, 3'd0);
    check("late_done_serv", add_serv_o[0], 1'b0);
    check("late_done_op1", op1_o[0], 32'h0);
    tick();
    check("rst_no_serv", servs[0] - v0, 0);

    // Normal operation after the abandoned sum.
    feed(0, 32'h40200000);
    feed(0, 32'h40600000);
    wait_start(0, o1, o2);
    check("after_rst_op1", o1, 32'h40200000);
    do_add(0, 5, 32'h40C00000, 1'b0);
    take_sum(0, 32'h40C00000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
